// File: rtl/voxel_read_arbiter.sv
// Round-robin arbiter sharing one voxel RAM read port with a fixed one-cycle response.
// Optional per-requester grant/stall statistics counters: define VOXEL_ARB_STATS_EN.
module voxel_read_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_BITS = 15,
   parameter int SYNC_READ = 1,
   parameter int CNT_BITS  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_mode,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*ADDR_BITS-1:0]  req_addr,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            resp_valid,
   output logic                        resp_occ,
   output logic [ADDR_BITS-1:0]        ram_raddr,
   input  logic                        ram_rdata,
   output logic                        idle,
   input  logic                        stats_clr,
   output logic [N_REQ*CNT_BITS-1:0]   grant_cnt,
   output logic [N_REQ*CNT_BITS-1:0]   stall_cnt
);

   localparam int PTR_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_BITS-1:0]  rr_ptr;
   logic [PTR_BITS-1:0]  grant_idx;
   logic                 grant_any;
   logic [N_REQ-1:0]     grant;
   logic [N_REQ-1:0]     resp_pending;
   logic [ADDR_BITS-1:0] grant_addr;
   logic [ADDR_BITS-1:0] last_addr;

   // Search starts at rr_ptr and wraps; load_mode suppresses every grant.
   always_comb begin
      int idx;
      idx        = 0;
      grant      = '0;
      grant_idx  = '0;
      grant_any  = 1'b0;
      grant_addr = '0;
      if (!load_mode) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_any && req_valid[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = PTR_BITS'(idx);
               grant_any  = 1'b1;
               grant_addr = req_addr[idx*ADDR_BITS +: ADDR_BITS];
            end
         end
      end
   end

   assign req_ready  = grant;
   assign ram_raddr  = grant_any ? grant_addr : last_addr;
   assign resp_valid = resp_pending;
   assign idle       = ~|req_valid & ~|resp_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         last_addr    <= '0;
         resp_pending <= '0;
      end else begin
         resp_pending <= grant;
         if (grant_any) begin
            rr_ptr    <= (grant_idx == PTR_BITS'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            last_addr <= grant_addr;
         end
      end
   end

   generate
      if (SYNC_READ != 0) begin : g_sync_read
         assign resp_occ = (|resp_pending) & ram_rdata;
      end else begin : g_comb_read
         logic occ_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               occ_q <= 1'b0;
            end else begin
               occ_q <= grant_any & ram_rdata;
            end
         end
         assign resp_occ = occ_q;
      end
   endgenerate

`ifdef VOXEL_ARB_STATS_EN
   for (genvar i = 0; i < N_REQ; i++) begin : g_stats
      logic [CNT_BITS-1:0] gcnt;
      logic [CNT_BITS-1:0] scnt;
      // Clear has priority; both counters saturate at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            gcnt <= '0;
            scnt <= '0;
         end else if (stats_clr) begin
            gcnt <= '0;
            scnt <= '0;
         end else begin
            if (req_valid[i] && grant[i] && gcnt != '1) gcnt <= gcnt + 1'b1;
            if (req_valid[i] && !grant[i] && scnt != '1) scnt <= scnt + 1'b1;
         end
      end
      assign grant_cnt[i*CNT_BITS +: CNT_BITS] = gcnt;
      assign stall_cnt[i*CNT_BITS +: CNT_BITS] = scnt;
   end
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign grant_cnt        = '0;
   assign stall_cnt        = '0;
`endif

endmodule

// File: tb/tb_voxel_read_arbiter.sv
// Table-driven bench for voxel_read_arbiter with a response scoreboard and a simple sync RAM.
module tb_voxel_read_arbiter;

   localparam int NR = 4;
   localparam int AB = 15;
`ifdef VOXEL_ARB_STATS_EN
   localparam int CB = 4;
`else
   localparam int CB = 16;
`endif

   typedef struct {
      logic          lm;
      logic [NR-1:0] rv;
      logic [NR-1:0] rdy;
   } vec_t;

   typedef struct {
      logic [NR-1:0] v;
      logic          occ;
   } sb_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               load_mode = 1'b0;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*AB-1:0]   req_addr;
   logic [NR-1:0]      req_ready;
   logic [NR-1:0]      resp_valid;
   logic               resp_occ;
   logic [AB-1:0]      ram_raddr;
   logic               ram_rdata = 1'b0;
   logic               idle;
   logic               stats_clr = 1'b0;
   logic [NR*CB-1:0]   grant_cnt;
   logic [NR*CB-1:0]   stall_cnt;

   int checks = 0;
   int failures = 0;
   sb_t sbq[$];
   logic [AB-1:0] addrs[NR];
   logic [AB-1:0] last_addr = '0;
   logic [NR-1:0] prev_rdy = '0;
   vec_t vecs[27];

   voxel_read_arbiter #(
      .N_REQ(NR), .ADDR_BITS(AB), .SYNC_READ(1), .CNT_BITS(CB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .req_valid(req_valid),
      .req_addr(req_addr), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_occ(resp_occ), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .idle(idle),
      .stats_clr(stats_clr), .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // RAM contents: occupancy is address bit 2.
   always @(posedge clk) ram_rdata <= ram_raddr[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic lm, input logic [NR-1:0] rv, input logic [NR-1:0] exp_rdy);
      sb_t e;
      int gi;
      @(negedge clk);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("resp_valid", 32'(resp_valid), 32'(e.v));
         chk("resp_occ", 32'(resp_occ), 32'(e.occ));
      end
      load_mode = lm;
      req_valid = rv;
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("idle", 32'(idle), 32'(rv == '0 && prev_rdy == '0));
      if (exp_rdy != '0) begin
         gi = 0;
         for (int i = 0; i < NR; i++) if (exp_rdy[i]) gi = i;
         chk("ram_raddr", 32'(ram_raddr), 32'(addrs[gi]));
         last_addr = addrs[gi];
         sbq.push_back('{v: exp_rdy, occ: addrs[gi][2]});
      end else begin
         chk("ram_raddr_hold", 32'(ram_raddr), 32'(last_addr));
         sbq.push_back('{v: '0, occ: 1'b0});
      end
      prev_rdy = exp_rdy;
   endtask

   initial begin
      addrs[0] = 15'h0011;
      addrs[1] = 15'h0A5F;
      addrs[2] = 15'h1234;
      addrs[3] = 15'h7FF8;
      req_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};

      vecs[0]  = '{1'b0, 4'b0100, 4'b0100};
      vecs[1]  = '{1'b0, 4'b0000, 4'b0000};
      vecs[2]  = '{1'b0, 4'b0011, 4'b0001};
      vecs[3]  = '{1'b0, 4'b0011, 4'b0010};
      vecs[4]  = '{1'b0, 4'b0011, 4'b0001};
      vecs[5]  = '{1'b0, 4'b0000, 4'b0000};
      vecs[6]  = '{1'b0, 4'b1111, 4'b0010};
      vecs[7]  = '{1'b0, 4'b1111, 4'b0100};
      vecs[8]  = '{1'b0, 4'b1111, 4'b1000};
      vecs[9]  = '{1'b0, 4'b1111, 4'b0001};
      vecs[10] = '{1'b0, 4'b1111, 4'b0010};
      vecs[11] = '{1'b0, 4'b1111, 4'b0100};
      vecs[12] = '{1'b0, 4'b1111, 4'b1000};
      vecs[13] = '{1'b0, 4'b1111, 4'b0001};
      vecs[14] = '{1'b0, 4'b1111, 4'b0010};
      vecs[15] = '{1'b0, 4'b0100, 4'b0100};
      vecs[16] = '{1'b1, 4'b1111, 4'b0000};
      vecs[17] = '{1'b1, 4'b1111, 4'b0000};
      vecs[18] = '{1'b1, 4'b1111, 4'b0000};
      vecs[19] = '{1'b1, 4'b1111, 4'b0000};
      vecs[20] = '{1'b1, 4'b1111, 4'b0000};
      vecs[21] = '{1'b0, 4'b1111, 4'b1000};
      vecs[22] = '{1'b1, 4'b0000, 4'b0000};
      vecs[23] = '{1'b0, 4'b1000, 4'b1000};
      vecs[24] = '{1'b0, 4'b1000, 4'b1000};
      vecs[25] = '{1'b0, 4'b0000, 4'b0000};
      vecs[26] = '{1'b0, 4'b0000, 4'b0000};

      // Reset state.
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_occ", 32'(resp_occ), 32'h0);
      chk("rst_ram_raddr", 32'(ram_raddr), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      sbq.push_back('{v: '0, occ: 1'b0});

      for (int i = 0; i < 27; i++) step(vecs[i].lm, vecs[i].rv, vecs[i].rdy);

      // Reset while a response is in flight drops it and re-zeroes rr_ptr.
      step(1'b0, 4'b0010, 4'b0010);
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
      chk("midrst_resp_occ", 32'(resp_occ), 32'h0);
      chk("midrst_idle", 32'(idle), 32'h1);
      chk("midrst_ram_raddr", 32'(ram_raddr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
      sbq.push_back('{v: '0, occ: 1'b0});
      last_addr = '0;
      prev_rdy = '0;

      // Fairness from reset: 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, NR'(1) << (i % NR));
      step(1'b0, 4'b0000, 4'b0000);

`ifdef VOXEL_ARB_STATS_EN
      for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 4'b0001);
      step(1'b0, 4'b0000, 4'b0000);
      chk("grant_cnt0_sat", 32'(grant_cnt[CB-1:0]), 32'd15);
      stats_clr = 1'b1;
      step(1'b0, 4'b0000, 4'b0000);
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      chk("grant_cnt_clr", 32'(|grant_cnt), 32'h0);
      chk("stall_cnt_clr", 32'(|stall_cnt), 32'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 4'b0000);
      @(posedge clk);
      #1;
      chk("stall_cnt1", 32'(stall_cnt[CB +: CB]), 32'd3);
      step(1'b0, 4'b0000, 4'b0000);
`else
      chk("grant_cnt_tied", 32'(|grant_cnt), 32'h0);
      chk("stall_cnt_tied", 32'(|stall_cnt), 32'h0);
`endif
      step(1'b0, 4'b0000, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/voxel_read_arbiter.md
Name: voxel_read_arbiter

Overview:
Shares the single voxel occupancy RAM read port among N_REQ ray-traversal units using round-robin arbitration, at most one read issued per cycle. Hides the RAM read latency so that every requester sees a fixed one-cycle response. Blocks all reads while the scene loader owns the RAM (load_mode=1). Sits between the traversal step controllers and the voxel RAM read port.

Parameters:
N_REQ, 4, number of requesters (1..16)
ADDR_BITS, 15, voxel address width ({z,y,x} 5-5-5 mapping)
SYNC_READ, 1, must match the RAM: 1 = rdata valid one cycle after raddr; 0 = combinational rdata
CNT_BITS, 16, width of each statistics counter (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_mode  in  1  scene load active; no reads granted
req_valid  in  N_REQ  per-requester read request
req_addr  in  N_REQ*ADDR_BITS  flattened addresses; requester i at [i*ADDR_BITS +: ADDR_BITS]
req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
resp_valid  out  N_REQ  one-hot; occupancy result for requester i valid this cycle
resp_occ  out  1  occupancy bit, shared by all requesters, qualified by resp_valid
ram_raddr  out  ADDR_BITS  to RAM read address
ram_rdata  in  1  from RAM read data
idle  out  1  no req_valid asserted and no response in flight
stats_clr  in  1  synchronous clear of statistics counters
grant_cnt  out  N_REQ*CNT_BITS  per-requester grant counts (optional feature)
stall_cnt  out  N_REQ*CNT_BITS  per-requester stall cycles (optional feature)

Behaviour:
- Reset: rr_ptr=0, req_ready=0, resp_valid=0, resp_occ=0, ram_raddr=0, idle=1, all counters=0. Any in-flight response is dropped.
- Arbitration is combinational in cycle N. Search starts at rr_ptr and wraps modulo N_REQ. The first i with req_valid[i]=1 is granted: req_ready[i]=1, all others 0.
- After a grant to i: rr_ptr <= (i+1) mod N_REQ. With no grant, rr_ptr holds.
- With all N_REQ requesters continuously valid, each is granted exactly once every N_REQ cycles.
- req_ready depends on req_valid; it is never asserted for a non-requesting unit. Requesters hold req_valid and req_addr stable until accepted; dropping valid early is legal and simply withdraws the request.
- ram_raddr = addr of the granted requester in its grant cycle. With no grant, it holds the last issued address in a register (reset 0), so the RAM sees no spurious address toggling.
- Response latency is always 1 cycle. A grant to i in cycle N gives resp_valid[i]=1 in cycle N+1 only.
  - SYNC_READ=1: resp_occ = ram_rdata combinationally in N+1; resp_valid is the registered grant vector.
  - SYNC_READ=0: ram_rdata is registered in cycle N and presented in N+1.
- Back-to-back: a requester granted in N can be granted again in N+1 (when no other is valid). Its resp_valid is then high on consecutive cycles. No outstanding-read limit.
- load_mode=1: req_ready=0 for all requesters. A read granted in the cycle before load_mode rose still completes: resp_valid is asserted the next cycle. rr_ptr is frozen. Arbitration resumes the cycle after load_mode falls.
- idle = ~|req_valid & ~|resp_pending, where resp_pending is the registered grant vector. The scheduler waits for idle before asserting load_mode.
- N_REQ=1: granted whenever valid and load_mode=0; rr_ptr stays 0.
- No state machine beyond rr_ptr and the one-deep response pipeline. No backpressure on responses: requesters must accept resp_valid unconditionally.

Optional Feature:
Macro VOXEL_ARB_STATS_EN.
- Defined: per requester i:
  - grant_cnt[i] increments on each accepted request.
  - stall_cnt[i] increments each cycle req_valid[i]&~req_ready[i], including load_mode cycles.
  - Both counters saturate at 2^CNT_BITS-1.
  - stats_clr=1 zeroes all counters the next edge; clear wins over a same-cycle increment.
- Not defined: grant_cnt and stall_cnt are tied to 0, stats_clr is ignored, and no counter flops are built. Ports remain present so integration is unchanged.

Test Plan:
- Single requester: N_REQ=4, req_valid=4'b0100, addr 0x1234, RAM holds 1 there -> req_ready=4'b0100 in cycle N, ram_raddr=0x1234, resp_valid=4'b0100 and resp_occ=1 in N+1, rr_ptr=3.
- Fairness: req_valid=4'b1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; resp_valid follows one cycle later with each requester's own occupancy value.
- Wrap and skip: rr_ptr=3, req_valid=4'b0011 -> grant 0 then 1 then 0; requester 3 never granted while invalid; ram_raddr holds last address in empty cycles.
- Load blocking: grant to 2 in cycle N, load_mode=1 from N+1 for 5 cycles with req_valid=4'b1111 -> resp_valid[2]=1 in N+1, no req_ready during load, first grant after load_mode falls goes to 3.
- Reset mid-flight: grant in cycle N, rst_n low in N+1 -> resp_valid=0, rr_ptr=0, idle=1 after release with no requests.
- With VOXEL_ARB_STATS_EN, CNT_BITS=4: requester 0 granted 20 times -> grant_cnt[0]=15 (saturated); stats_clr pulse -> 0 next cycle; requester 1 blocked 3 cycles -> stall_cnt[1]=3.
